alu_arbiter: RTL

- Shares the single combinational `alu` between two requesters: requester 0 is the pipeline EX stage, requester 1 is the branch/address helper.
- Arbitrates with a valid/ready handshake and latches the winner's operands into an issue register.
- Captures the ALU result into a one-entry response buffer tagged with the requester ID.
- Sits between the decode/EX logic and the `alu` instance, and owns that instance.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_arbiter_if.sv | 36 +++
 rtl/alu.sv | 29 ++
 rtl/alu_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, arbiter state encoding and requester ID type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arbState_t;

  localparam int ID_W = 1;
  typedef logic [ID_W-1:0] reqId_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between the two ALU requesters, the result consumer and alu_arbiter.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             req0Valid;
  logic             req1Valid;
  logic             req0Ready;
  logic             req1Ready;
  logic [WIDTH-1:0] req0Data1;
  logic [WIDTH-1:0] req0Data2;
  logic [WIDTH-1:0] req1Data1;
  logic [WIDTH-1:0] req1Data2;
  logic [3:0]       req0Ctr;
  logic [3:0]       req1Ctr;
  logic             rspValid;
  logic             rspReady;
  reqId_t           rspId;
  logic [WIDTH-1:0] rspData;
  logic             busy;

  modport master (
    output req0Valid, req1Valid, req0Data1, req0Data2, req1Data1, req1Data2,
           req0Ctr, req1Ctr, rspReady,
    input  req0Ready, req1Ready, rspValid, rspId, rspData, busy
  );

  modport slave (
    input  req0Valid, req1Valid, req0Data1, req0Data2, req1Data1, req1Data2,
           req0Ctr, req1Ctr, rspReady,
    output req0Ready, req1Ready, rspValid, rspId, rspData, busy
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; unimplemented control codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ctr,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (ctr)
      ALU_AND: result = data1 & data2;
      ALU_OR:  result = data1 | data2;
      ALU_ADD: result = data1 + data2;
      ALU_SUB: result = data1 - data2;
      ALU_NOR: result = ~(data1 | data2);
      ALU_SLL: result = data1 << data2[4:0];
      ALU_SRL: result = data1 >> data2[4:0];
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      ALU_LUI: result = {data2[15:0], {(WIDTH-16){1'b0}}};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU: issue register, one-entry tagged response buffer.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rstN,
  alu_arbiter_if.slave bus
);

  arbState_t        state;
  logic [WIDTH-1:0] issueData1;
  logic [WIDTH-1:0] issueData2;
  logic [3:0]       issueCtr;
  reqId_t           issueId;
  logic             rspValidQ;
  reqId_t           rspIdQ;
  logic [WIDTH-1:0] rspDataQ;
  logic [WIDTH-1:0] aluOutData;

  logic             anyValid;
  logic             accept;
  reqId_t           grantId;
  logic [WIDTH-1:0] selData1;
  logic [WIDTH-1:0] selData2;
  logic [3:0]       selCtr;

`ifndef ALU_ARB_FIXED_PRIO_EN
  reqId_t           lastId;
`endif

  // Winner selection; only one requester can ever be granted per cycle.
  always_comb begin
    anyValid = bus.req0Valid | bus.req1Valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grantId = bus.req0Valid ? 1'b0 : 1'b1;
`else
    if (bus.req0Valid && bus.req1Valid) begin
      grantId = ~lastId;
    end else begin
      grantId = bus.req1Valid;
    end
`endif
    accept   = rstN && anyValid &&
               ((state == IDLE) || ((state == RESP) && bus.rspReady));
    selData1 = (grantId == 1'b1) ? bus.req1Data1 : bus.req0Data1;
    selData2 = (grantId == 1'b1) ? bus.req1Data2 : bus.req0Data2;
    selCtr   = (grantId == 1'b1) ? bus.req1Ctr   : bus.req0Ctr;
  end

  assign bus.req0Ready = accept && (grantId == 1'b0);
  assign bus.req1Ready = accept && (grantId == 1'b1);
  assign bus.rspValid  = rspValidQ;
  assign bus.rspId     = rspIdQ;
  assign bus.rspData   = rspDataQ;
  assign bus.busy      = (state != IDLE);

  // The ALU always sees the issue register, so its inputs stay quiet outside EXEC.
  alu #(.WIDTH(WIDTH)) aluInst (
    .data1  (issueData1),
    .data2  (issueData2),
    .ctr    (issueCtr),
    .result (aluOutData)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      issueData1 <= '0;
      issueData2 <= '0;
      issueCtr   <= '0;
      issueId    <= '0;
      rspValidQ  <= 1'b0;
      rspIdQ     <= '0;
      rspDataQ   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      lastId     <= 1'b1;
`endif
    end else begin
      if (accept) begin
        issueData1 <= selData1;
        issueData2 <= selData2;
        issueCtr   <= selCtr;
        issueId    <= grantId;
`ifndef ALU_ARB_FIXED_PRIO_EN
        lastId     <= grantId;
`endif
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          rspDataQ  <= aluOutData;
          rspIdQ    <= issueId;
          rspValidQ <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.rspReady) begin
            rspValidQ <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
